dii_packet_rx: RTL and testbench



---
 rtl/dii_pkg.sv | 41 ++++
 rtl/dii_packet_rx_if.sv | 10 +
 rtl/dii_payload_buf.sv | 39 +++
 rtl/dii_packet_rx.sv | 126 ++++++++++++
 tb/tb_dii_packet_rx.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dii_pkg.sv
// rtl/dii_pkg.sv - shared types and constants for the debug interconnect flit channel
package dii_pkg;

   // One flit as seen on the channel
   typedef struct packed {
      logic        last;
      logic [15:0] data;
   } dii_flit;

   // Header word positions within a packet
   localparam int HDR_DEST  = 0;
   localparam int HDR_SRC   = 1;
   localparam int HDR_FLAGS = 2;

   // Field positions inside the flags word
   localparam int TYPE_MSB     = 15;
   localparam int TYPE_LSB     = 14;
   localparam int TYPE_SUB_MSB = 13;
   localparam int TYPE_SUB_LSB = 10;

   typedef enum logic [1:0] {
      TYPE_REG   = 2'd0,
      TYPE_PLAIN = 2'd1,
      TYPE_EVENT = 2'd2
   } dii_type_e;

   typedef enum logic [2:0] {
      ST_DEST,
      ST_SRC,
      ST_FLAGS,
      ST_PAYLOAD,
      ST_DROP,
      ST_HOLD
   } rx_state_e;

   // Increment that sticks at 255 instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dii_packet_rx_if.sv
// rtl/dii_packet_rx_if.sv - flit channel bundle with valid/last/ready handshake
interface dii_packet_rx_if;
   logic        valid;
   logic        last;
   logic [15:0] data;
   logic        ready;

   modport master (output valid, output last, output data, input ready);
   modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/dii_payload_buf.sv
// rtl/dii_payload_buf.sv - write-indexed payload store with length counter and truncate flag
module dii_payload_buf #(
   parameter int MAX_PAYLOAD = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [15:0]              wr_data,
   output logic [4:0]               len,
   output logic                     truncated,
   output logic [16*MAX_PAYLOAD-1:0] payload
);

   // Append words at index len; words beyond capacity only raise truncated.
   // clear restarts a packet but leaves old slot contents in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         len       <= 5'd0;
         truncated <= 1'b0;
         payload   <= '0;
      end else if (clear) begin
         len       <= 5'd0;
         truncated <= 1'b0;
      end else if (wr_en) begin
         if (len < 5'(MAX_PAYLOAD)) begin
            for (int i = 0; i < MAX_PAYLOAD; i++) begin
               if (len == 5'(i)) begin
                  payload[16*i +: 16] <= wr_data;
               end
            end
            len <= len + 5'd1;
         end else begin
            truncated <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/dii_packet_rx.sv
// rtl/dii_packet_rx.sv - flit receiver: header parse, dest filter, packet hold until ack
module dii_packet_rx
   import dii_pkg::*;
#(
   parameter int MAX_PAYLOAD = 8,
   parameter int FILTER_DEST = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [15:0]               id,
   dii_packet_rx_if.slave            in_if,
   output logic                      pkt_valid,
   input  logic                      pkt_ack,
   output logic [15:0]               pkt_dest,
   output logic [15:0]               pkt_src,
   output logic [1:0]                pkt_type,
   output logic [3:0]                pkt_type_sub,
   output logic [4:0]                pkt_len,
   output logic [16*MAX_PAYLOAD-1:0] pkt_payload,
   output logic                      pkt_truncated,
   output logic [7:0]                drop_count
);

   rx_state_e state;
   logic      in_ready_q;
   dii_flit   flit;
   logic      xfer;

   assign flit        = '{last: in_if.last, data: in_if.data};
   assign in_if.ready = in_ready_q;
   assign xfer        = in_if.valid & in_ready_q;

   dii_payload_buf #(
      .MAX_PAYLOAD(MAX_PAYLOAD)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .clear    (xfer && (state == ST_FLAGS)),
      .wr_en    (xfer && (state == ST_PAYLOAD)),
      .wr_data  (flit.data),
      .len      (pkt_len),
      .truncated(pkt_truncated),
      .payload  (pkt_payload)
   );

   // Packet parser FSM; in_ready and pkt_valid are registered so nothing on the
   // input side feeds straight through to in_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_DEST;
         in_ready_q   <= 1'b0;
         pkt_valid    <= 1'b0;
         pkt_dest     <= 16'd0;
         pkt_src      <= 16'd0;
         pkt_type     <= 2'd0;
         pkt_type_sub <= 4'd0;
         drop_count   <= 8'd0;
      end else begin
         in_ready_q <= 1'b1;
         case (state)
            ST_DEST: begin
               if (xfer) begin
                  pkt_dest <= flit.data;
                  if (flit.last) begin
                     drop_count <= sat_inc8(drop_count);
                  end else if ((FILTER_DEST != 0) && (flit.data != id)) begin
                     state <= ST_DROP;
                  end else begin
                     state <= ST_SRC;
                  end
               end
            end
            ST_SRC: begin
               if (xfer) begin
                  pkt_src <= flit.data;
                  if (flit.last) begin
                     drop_count <= sat_inc8(drop_count);
                     state      <= ST_DEST;
                  end else begin
                     state <= ST_FLAGS;
                  end
               end
            end
            ST_FLAGS: begin
               if (xfer) begin
                  pkt_type     <= flit.data[TYPE_MSB:TYPE_LSB];
                  pkt_type_sub <= flit.data[TYPE_SUB_MSB:TYPE_SUB_LSB];
                  if (flit.last) begin
                     state      <= ST_HOLD;
                     in_ready_q <= 1'b0;
                     pkt_valid  <= 1'b1;
                  end else begin
                     state <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (xfer && flit.last) begin
                  state      <= ST_HOLD;
                  in_ready_q <= 1'b0;
                  pkt_valid  <= 1'b1;
               end
            end
            ST_DROP: begin
               if (xfer && flit.last) begin
                  drop_count <= sat_inc8(drop_count);
                  state      <= ST_DEST;
               end
            end
            ST_HOLD: begin
               if (pkt_ack) begin
                  state     <= ST_DEST;
                  pkt_valid <= 1'b0;
               end else begin
                  in_ready_q <= 1'b0;
               end
            end
            default: begin
               state     <= ST_DEST;
               pkt_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dii_packet_rx.sv
// tb/tb_dii_packet_rx.sv - scoreboard bench for dii_packet_rx with packet-level reference model
module tb_dii_packet_rx;

   localparam int MAX = 8;
   localparam int FILT = 1;
   localparam logic [15:0] ID = 16'h0005;

   typedef struct {
      logic [15:0] dest;
      logic [15:0] src;
      logic [1:0]  typ;
      logic [3:0]  sub;
      int          len;
      logic        trunc;
      logic [15:0] pl [16];
      int          drops;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [15:0]      id;
   logic             pkt_valid;
   logic             pkt_ack;
   logic [15:0]      pkt_dest, pkt_src;
   logic [1:0]       pkt_type;
   logic [3:0]       pkt_type_sub;
   logic [4:0]       pkt_len;
   logic [16*MAX-1:0] pkt_payload;
   logic             pkt_truncated;
   logic [7:0]       drop_count;

   dii_packet_rx_if in_if ();

   dii_packet_rx #(
      .MAX_PAYLOAD(MAX),
      .FILTER_DEST(FILT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id           (id),
      .in_if        (in_if.slave),
      .pkt_valid    (pkt_valid),
      .pkt_ack      (pkt_ack),
      .pkt_dest     (pkt_dest),
      .pkt_src      (pkt_src),
      .pkt_type     (pkt_type),
      .pkt_type_sub (pkt_type_sub),
      .pkt_len      (pkt_len),
      .pkt_payload  (pkt_payload),
      .pkt_truncated(pkt_truncated),
      .drop_count   (drop_count)
   );

   always #5 clk = ~clk;

   int   total = 0;
   int   passed = 0;
   exp_t sb [$];
   int   model_drops = 0;
   int   gap_max = 0;
   int   force_hold = -1;
   bit   busy = 1'b0;
   int   cyc = 0;
   int   last_xfer_cyc = -1;

   function automatic void chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // Reference: a packet of fewer than three flits, or addressed elsewhere, is a drop;
   // otherwise the first MAX payload words are kept and any surplus marks truncation.
   function automatic void model_packet(input logic [15:0] w [$]);
      exp_t e;
      int   n = w.size();
      if (n < 3 || (FILT != 0 && w[0] != ID)) begin
         if (model_drops < 255) model_drops++;
         return;
      end
      e.dest  = w[0];
      e.src   = w[1];
      e.typ   = w[2][15:14];
      e.sub   = w[2][13:10];
      e.len   = (n - 3 > MAX) ? MAX : n - 3;
      e.trunc = (n - 3 > MAX);
      for (int i = 0; i < 16; i++) e.pl[i] = 16'd0;
      for (int i = 0; i < e.len; i++) e.pl[i] = w[3 + i];
      e.drops = model_drops;
      sb.push_back(e);
   endfunction

   task automatic send_flit(input logic [15:0] d, input logic l);
      int b = 0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      in_if.valid = 1'b1;
      in_if.data  = d;
      in_if.last  = l;
      while (!in_if.ready && b < 1000) begin
         @(negedge clk);
         b++;
      end
      if (b >= 1000) chk("accept_timeout", 0, 1);
      else @(negedge clk);
      in_if.valid = 1'b0;
      in_if.last  = 1'b0;
   endtask

   task automatic send_packet(input logic [15:0] w [$]);
      model_packet(w);
      foreach (w[i]) send_flit(w[i], (i == w.size() - 1));
   endtask

   task automatic drain();
      int b = 0;
      while ((sb.size() != 0 || pkt_valid || busy) && b < 500) begin
         @(negedge clk);
         b++;
      end
      chk("drain_done", (b < 500), 1);
   endtask

   task automatic reset_checks(input string tag);
      chk({tag, "_in_ready"}, in_if.ready, 0);
      chk({tag, "_pkt_valid"}, pkt_valid, 0);
      chk({tag, "_hdr"}, {pkt_dest, pkt_src, pkt_type, pkt_type_sub}, 0);
      chk({tag, "_len"}, pkt_len, 0);
      chk({tag, "_payload"}, pkt_payload, 0);
      chk({tag, "_trunc"}, pkt_truncated, 0);
      chk({tag, "_drops"}, drop_count, 0);
   endtask

   // Cycle counter and the cycle of the most recent final-flit transfer
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (in_if.valid && in_if.ready && in_if.last) last_xfer_cyc <= cyc + 1;
   end

   // Monitor: pop the expected packet when pkt_valid appears, watch it hold, then ack
   initial begin
      exp_t e;
      logic [63:0]       snap;
      logic [16*MAX-1:0] snap_pl;
      int                d;
      pkt_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && pkt_valid) begin
            busy = 1'b1;
            if (sb.size() == 0) begin
               chk("unexpected_pkt", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("latency", cyc, last_xfer_cyc);
               chk("dest", pkt_dest, e.dest);
               chk("src", pkt_src, e.src);
               chk("type", pkt_type, e.typ);
               chk("type_sub", pkt_type_sub, e.sub);
               chk("len", pkt_len, e.len);
               chk("truncated", pkt_truncated, e.trunc);
               chk("drop_count", drop_count, e.drops);
               for (int i = 0; i < e.len; i++) chk("payload_word", pkt_payload[16*i +: 16], e.pl[i]);
            end
            snap    = {pkt_dest, pkt_src, pkt_type, pkt_type_sub, pkt_len, pkt_truncated, drop_count};
            snap_pl = pkt_payload;
            d = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
            force_hold = -1;
            repeat (d) begin
               @(negedge clk);
               chk("hold_in_ready", in_if.ready, 0);
               chk("hold_valid", pkt_valid, 1);
               chk("hold_stable", {pkt_dest, pkt_src, pkt_type, pkt_type_sub, pkt_len, pkt_truncated, drop_count}, snap);
               chk("hold_payload", pkt_payload, snap_pl);
            end
            pkt_ack = 1'b1;
            @(negedge clk);
            pkt_ack = 1'b0;
            chk("ack_valid_low", pkt_valid, 0);
            chk("ack_in_ready", in_if.ready, 1);
            busy = 1'b0;
         end
      end
   end

   // Stimulus
   initial begin
      logic [15:0] pkt [$];
      int          n;
      rst = 1'b1;
      id  = ID;
      in_if.valid = 1'b0;
      in_if.last  = 1'b0;
      in_if.data  = 16'd0;
      repeat (3) @(negedge clk);
      reset_checks("reset");
      rst = 1'b0;
      @(negedge clk);

      // Basic packet with two payload words
      gap_max = 0;
      pkt = {16'h0005, 16'h0001, 16'h8000, 16'h1234, 16'hABCD};
      send_packet(pkt);

      // Header-only packet held for ten cycles before ack
      drain();
      force_hold = 10;
      pkt = {16'h0005, 16'h0002, 16'h4400};
      send_packet(pkt);

      // Oversized payload, then a packet that must clear truncation
      pkt = {16'h0005, 16'h0003, 16'h0000};
      for (int i = 0; i < 11; i++) pkt.push_back(16'(i));
      send_packet(pkt);
      pkt = {16'h0005, 16'h0004, 16'h0000, 16'h00EE};
      send_packet(pkt);

      // Filtered destination, then a good packet
      pkt = {16'h0006, 16'h0001, 16'h0000, 16'h1111};
      send_packet(pkt);
      drain();
      chk("filter_drop", drop_count, model_drops);
      pkt = {16'h0005, 16'h0001, 16'h0000, 16'h2222, 16'h3333};
      send_packet(pkt);

      // Malformed two-flit packet, then enough single-flit packets to saturate
      pkt = {16'h0005, 16'h0001};
      send_packet(pkt);
      for (int i = 0; i < 300; i++) begin
         pkt = {16'h0005};
         send_packet(pkt);
      end
      drain();
      chk("drop_saturated", drop_count, 255);
      pkt = {16'h0005, 16'h0009, 16'h8C00, 16'h5A5A};
      send_packet(pkt);

      // Reset in the middle of a six-word payload
      drain();
      gap_max = 2;
      send_flit(16'h0005, 1'b0);
      send_flit(16'h0007, 1'b0);
      send_flit(16'h0000, 1'b0);
      send_flit(16'h0001, 1'b0);
      send_flit(16'h0002, 1'b0);
      send_flit(16'h0003, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      reset_checks("midreset");
      rst = 1'b0;
      model_drops = 0;
      @(negedge clk);
      pkt = {16'h0005, 16'h0008, 16'hC000};
      for (int i = 0; i < 6; i++) pkt.push_back(16'($urandom));
      send_packet(pkt);

      // Randomised packets with random gaps
      gap_max = 3;
      for (int k = 0; k < 40; k++) begin
         n = int'($urandom_range(1, 14));
         pkt = {};
         pkt.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : ID);
         for (int i = 1; i < n; i++) pkt.push_back(16'($urandom));
         send_packet(pkt);
      end
      drain();
      chk("final_drops", drop_count, model_drops);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
